// File: rtl/fht_pkg.sv
// Shared constants and types for the FHT sequencer / address generator.
package fht_pkg;

  localparam int N      = 256;               // transform length (power of 2, >= 16)
  localparam int A_BIT  = $clog2(N) - 2;     // bank address width, N/4 words per bank
  localparam int LAT    = 4;                 // butterfly latency, read address to write address
  localparam int STAGES = A_BIT + 1;         // number of FHT stages

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH
  } state_t;

endpackage

// File: rtl/fht_addr_gen.sv
// Combinational butterfly address map: bank word j at stage s -> sector bias,
// mirrored read address, twiddle address, sector index and upper-half flag.
module fht_addr_gen
  import fht_pkg::*;
#(
  parameter int AW = A_BIT,
  parameter int SW = $clog2(AW + 1)
) (
  input  logic [AW-1:0] j,
  input  logic [SW-1:0] s,
  output logic [AW-1:0] bias,
  output logic [AW-1:0] rd_lo,
  output logic [AW-1:0] rd_hi,
  output logic [AW-1:0] coef,
  output logic [AW-1:0] sector,
  output logic          upper
);

  logic [AW:0]   k_size;   // sector size K = 2^s, one bit wider so K = N/4 fits
  logic [AW-1:0] mask;     // K-1
  logic [AW-1:0] k;        // offset of j inside its sector

  // Split j into sector base and offset, then mirror the offset inside the sector.
  always_comb begin
    k_size = {{AW{1'b0}}, 1'b1} << s;
    // At the last stage K = N/4 wraps to 0 in AW bits, so the mask becomes all ones.
    mask   = k_size[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
    bias   = j & ~mask;
    k      = j & mask;
    rd_lo  = bias | k;
    rd_hi  = bias | ((k_size[AW-1:0] - k) & mask);
    coef   = k << (AW - int'(s));
    sector = j >> s;
    upper  = (s != '0) && ({1'b0, k} >= (k_size >> 1));
  end

endmodule

// File: rtl/fht_ctrl.sv
// Stage sequencer for an in-place radix-2 FHT: one butterfly per cycle,
// registered read/twiddle addresses, LAT-deep write path and ping-pong control.
module fht_ctrl
  import fht_pkg::*;
#(
  parameter int NPT     = N,
  parameter int AW      = A_BIT,
  parameter int LATENCY = LAT
) (
  input  logic          iCLK,
  input  logic          iRESET,
  input  logic          iSTART,
  output logic          oST_ZERO,
  output logic          oST_LAST,
  output logic          o2ND_PART_SUBSEC,
  output logic [AW-1:0] oSECTOR,
  output logic [AW-1:0] oADDR_RD_0,
  output logic [AW-1:0] oADDR_RD_1,
  output logic [AW-1:0] oADDR_RD_2,
  output logic [AW-1:0] oADDR_RD_3,
  output logic [AW-1:0] oADDR_WR,
  output logic [AW-1:0] oADDR_WR_BIAS,
  output logic [AW-1:0] oADDR_COEF,
  output logic          oWE_A,
  output logic          oWE_B,
  output logic          oSOURCE_DATA,
  output logic          oSOURCE_CONT,
  output logic          oRDY
);

  localparam int SW = $clog2(AW + 1);
  localparam int FW = $clog2(LATENCY + 1);
  localparam logic [AW-1:0] J_LAST = AW'(NPT / 4 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(AW);

  state_t        state;
  logic [AW-1:0] addr_rd;
  logic [AW-1:0] addr_rd_bias;
  logic [SW-1:0] stage;
  logic          EOF_READ;
  logic [FW-1:0] flush_cnt;
  logic          flush_last;

  logic          ld;
  logic [AW-1:0] j_nxt;
  logic [SW-1:0] s_nxt;

  logic [AW-1:0] g_bias, g_rd_lo, g_rd_hi, g_coef, g_sector;
  logic          g_upper;

  logic [AW-1:0]      wr_addr_q [LATENCY];
  logic [AW-1:0]      wr_bias_q [LATENCY];
  logic [LATENCY-1:0] we_a_q;
  logic [LATENCY-1:0] we_b_q;

  assign flush_last = (flush_cnt == FW'(LATENCY - 1));

  // Next butterfly index and stage; ld marks cycles where they change, so the
  // address registers hold their value through FLUSH and IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise paths that skip an assignment infer latches.
    ld    = 1'b0;
    j_nxt = addr_rd;
    s_nxt = stage;
    unique case (state)
      IDLE: if (iSTART) begin
        ld    = 1'b1;
        j_nxt = '0;
        s_nxt = '0;
      end
      READ: if (addr_rd != J_LAST) begin
        ld    = 1'b1;
        j_nxt = addr_rd + 1'b1;
      end
      FLUSH: if (flush_last && stage != S_LAST) begin
        ld    = 1'b1;
        j_nxt = '0;
        s_nxt = stage + 1'b1;
      end
      default: ;
    endcase
  end

  // Address map evaluated on the next index so the registered outputs line up with addr_rd.
  fht_addr_gen #(.AW(AW), .SW(SW)) u_addr_gen (
    .j      (j_nxt),
    .s      (s_nxt),
    .bias   (g_bias),
    .rd_lo  (g_rd_lo),
    .rd_hi  (g_rd_hi),
    .coef   (g_coef),
    .sector (g_sector),
    .upper  (g_upper)
  );

  // Control FSM, counters and registered read-side outputs.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state            <= IDLE;
      stage            <= '0;
      addr_rd          <= '0;
      addr_rd_bias     <= '0;
      EOF_READ         <= 1'b1;
      flush_cnt        <= '0;
      oRDY             <= 1'b1;
      oSOURCE_CONT     <= 1'b0;
      oSOURCE_DATA     <= 1'b0;
      oST_ZERO         <= 1'b0;
      oST_LAST         <= 1'b0;
      o2ND_PART_SUBSEC <= 1'b0;
      oSECTOR          <= '0;
      oADDR_RD_0       <= '0;
      oADDR_RD_1       <= '0;
      oADDR_RD_2       <= '0;
      oADDR_RD_3       <= '0;
      oADDR_COEF       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (ld) begin
        addr_rd          <= j_nxt;
        stage            <= s_nxt;
        addr_rd_bias     <= g_bias;
        oSOURCE_DATA     <= s_nxt[0];
        oST_ZERO         <= (s_nxt == '0);
        oST_LAST         <= (s_nxt == S_LAST);
        o2ND_PART_SUBSEC <= g_upper;
        oSECTOR          <= g_sector;
        oADDR_RD_0       <= g_rd_lo;
        oADDR_RD_1       <= g_rd_lo;
        oADDR_RD_2       <= g_rd_hi;
        oADDR_RD_3       <= g_rd_hi;
        oADDR_COEF       <= g_coef;
      end
      unique case (state)
        IDLE: if (iSTART) begin
          state        <= READ;
          EOF_READ     <= 1'b0;
          oRDY         <= 1'b0;
          oSOURCE_CONT <= 1'b1;
        end
        READ: if (addr_rd == J_LAST) begin
          state     <= FLUSH;
          EOF_READ  <= 1'b1;
          flush_cnt <= '0;
        end
        FLUSH: begin
          if (flush_last) begin
            if (stage == S_LAST) begin
              state        <= IDLE;
              oRDY         <= 1'b1;
              oSOURCE_CONT <= 1'b0;
            end else begin
              state    <= READ;
              EOF_READ <= 1'b0;
            end
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-side delay line: read address, bias and valid delayed by the butterfly latency.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      // NOTE: this delay line is reset because an abandoned transform must not leave writes in flight.
      for (int i = 0; i < LATENCY; i++) begin
        wr_addr_q[i] <= '0;
        wr_bias_q[i] <= '0;
      end
      we_a_q <= '0;
      we_b_q <= '0;
    end else begin
      wr_addr_q[0] <= addr_rd;
      wr_bias_q[0] <= addr_rd_bias;
      we_a_q[0]    <= (state == READ) &  stage[0];
      we_b_q[0]    <= (state == READ) & ~stage[0];
      for (int i = 1; i < LATENCY; i++) begin
        wr_addr_q[i] <= wr_addr_q[i-1];
        wr_bias_q[i] <= wr_bias_q[i-1];
        we_a_q[i]    <= we_a_q[i-1];
        we_b_q[i]    <= we_b_q[i-1];
      end
    end
  end

  assign oADDR_WR      = wr_addr_q[LATENCY-1];
  assign oADDR_WR_BIAS = wr_bias_q[LATENCY-1];
  assign oWE_A         = we_a_q[LATENCY-1];
  assign oWE_B         = we_b_q[LATENCY-1];

endmodule

// File: tb/tb_fht_ctrl.sv
// Self-checking bench for fht_ctrl at N=16: every cycle of a transform is
// compared with a cycle-indexed arithmetic model of the stage schedule.
module tb_fht_ctrl;

  localparam int N    = 16;
  localparam int AW   = 2;
  localparam int LAT  = 4;
  localparam int NST  = AW + 1;
  localparam int NQ   = N / 4;
  localparam int PER  = NQ + LAT;
  localparam int BUSY = NST * PER;

  logic          iCLK = 1'b0;
  logic          iRESET;
  logic          iSTART;
  logic          oST_ZERO, oST_LAST, o2ND_PART_SUBSEC;
  logic [AW-1:0] oSECTOR, oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
  logic [AW-1:0] oADDR_WR, oADDR_WR_BIAS, oADDR_COEF;
  logic          oWE_A, oWE_B, oSOURCE_DATA, oSOURCE_CONT, oRDY;

  int n_checks = 0;
  int n_pass   = 0;

  fht_ctrl #(.NPT(N), .AW(AW), .LATENCY(LAT)) dut (
    .iCLK             (iCLK),
    .iRESET           (iRESET),
    .iSTART           (iSTART),
    .oST_ZERO         (oST_ZERO),
    .oST_LAST         (oST_LAST),
    .o2ND_PART_SUBSEC (o2ND_PART_SUBSEC),
    .oSECTOR          (oSECTOR),
    .oADDR_RD_0       (oADDR_RD_0),
    .oADDR_RD_1       (oADDR_RD_1),
    .oADDR_RD_2       (oADDR_RD_2),
    .oADDR_RD_3       (oADDR_RD_3),
    .oADDR_WR         (oADDR_WR),
    .oADDR_WR_BIAS    (oADDR_WR_BIAS),
    .oADDR_COEF       (oADDR_COEF),
    .oWE_A            (oWE_A),
    .oWE_B            (oWE_B),
    .oSOURCE_DATA     (oSOURCE_DATA),
    .oSOURCE_CONT     (oSOURCE_CONT),
    .oRDY             (oRDY)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  typedef struct {
    int s, j, rd, bias, rd0, rd2, coef, sector, upper;
  } ref_t;

  // Reference: cycle t after the start edge -> stage, index and butterfly addresses.
  function automatic ref_t model(input int t);
    ref_t r;
    int   w, kk, kw;
    r.s      = t / PER;
    w        = t % PER;
    r.rd     = (w < NQ) ? 1 : 0;
    r.j      = r.rd ? w : NQ - 1;
    kw       = 1 << r.s;
    r.bias   = (r.j / kw) * kw;
    kk       = r.j % kw;
    r.rd0    = r.bias + kk;
    r.rd2    = r.bias + ((kw - kk) % kw);
    r.coef   = kk * (NQ / kw);
    r.sector = r.j / kw;
    r.upper  = (r.s >= 1 && kk >= kw / 2) ? 1 : 0;
    return r;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},      oRDY, 1);
    check({tag, "_we_a"},     oWE_A, 0);
    check({tag, "_we_b"},     oWE_B, 0);
    check({tag, "_src_cont"}, oSOURCE_CONT, 0);
    check({tag, "_src_data"}, oSOURCE_DATA, 0);
    check({tag, "_st_zero"},  oST_ZERO, 0);
    check({tag, "_st_last"},  oST_LAST, 0);
    check({tag, "_rd0"},      oADDR_RD_0, 0);
    check({tag, "_rd2"},      oADDR_RD_2, 0);
    check({tag, "_coef"},     oADDR_COEF, 0);
    check({tag, "_wr"},       oADDR_WR, 0);
    check({tag, "_sector"},   oSECTOR, 0);
    check({tag, "_addr_rd"},  dut.addr_rd, 0);
    check({tag, "_stage"},    dut.stage, 0);
    check({tag, "_eof"},      dut.EOF_READ, 1);
  endtask

  // One transform from a start pulse; abort_at >= 0 asserts reset at that cycle.
  task automatic run_transform(input int abort_at);
    int   wa, wb, exp_a, exp_b;
    ref_t r, rw;
    wa = 0;
    wb = 0;
    iSTART = 1'b1;
    @(negedge iCLK);
    for (int t = 0; t <= BUSY; t++) begin
      if (t < BUSY) begin
        r = model(t);
        check("rdy_busy", oRDY, 0);
        check("src_cont", oSOURCE_CONT, 1);
        check("src_data", oSOURCE_DATA, r.s % 2);
        check("st_zero",  oST_ZERO, (r.s == 0) ? 1 : 0);
        check("st_last",  oST_LAST, (r.s == NST - 1) ? 1 : 0);
        check("stage",    dut.stage, r.s);
        check("addr_rd",  dut.addr_rd, r.j);
        check("eof",      dut.EOF_READ, r.rd ? 0 : 1);
        check("bias",     dut.addr_rd_bias, r.bias);
        check("rd0",      oADDR_RD_0, r.rd0);
        check("rd1",      oADDR_RD_1, r.rd0);
        check("rd2",      oADDR_RD_2, r.rd2);
        check("rd3",      oADDR_RD_3, r.rd2);
        check("coef",     oADDR_COEF, r.coef);
        check("sector",   oSECTOR, r.sector);
        check("2nd_part", o2ND_PART_SUBSEC, r.upper);
        exp_a = 0;
        exp_b = 0;
        if (t >= LAT) begin
          rw = model(t - LAT);
          if (rw.rd != 0) begin
            exp_a = rw.s % 2;
            exp_b = 1 - exp_a;
            check("wr_addr", oADDR_WR, rw.j);
            check("wr_bias", oADDR_WR_BIAS, rw.bias);
          end
        end
        check("we_a", oWE_A, exp_a);
        check("we_b", oWE_B, exp_b);
        wa += int'(oWE_A);
        wb += int'(oWE_B);
      end else begin
        r = model(BUSY - 1);
        check("rdy_done",      oRDY, 1);
        check("src_cont_done", oSOURCE_CONT, 0);
        check("we_a_done",     oWE_A, 0);
        check("we_b_done",     oWE_B, 0);
        check("eof_done",      dut.EOF_READ, 1);
        check("rd0_hold",      oADDR_RD_0, r.rd0);
        check("rd2_hold",      oADDR_RD_2, r.rd2);
        check("coef_hold",     oADDR_COEF, r.coef);
      end
      if (t == abort_at) begin
        iSTART = 1'b0;
        iRESET = 1'b1;
        #1;
        check_reset_vals("abort");
        @(negedge iCLK);
        iRESET = 1'b0;
        return;
      end
      // Spurious start pulses while busy must be ignored.
      iSTART = (t < BUSY) ? ($urandom_range(3) == 0) : 1'b0;
      if (t < BUSY) @(negedge iCLK);
    end
    check("wr_cnt_a", wa, NQ * (NST / 2));
    check("wr_cnt_b", wb, NQ * ((NST + 1) / 2));
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(5, 1);
    iSTART = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge iCLK);
      check("gap_rdy",  oRDY, 1);
      check("gap_we_a", oWE_A, 0);
      check("gap_we_b", oWE_B, 0);
    end
  endtask

  initial begin
    iRESET = 1'b1;
    iSTART = 1'b1;
    repeat (3) @(negedge iCLK);
    check_reset_vals("rst");
    iSTART = 1'b0;
    @(negedge iCLK);
    iRESET = 1'b0;
    repeat (3) @(negedge iCLK);
    check_reset_vals("idle");

    run_transform(-1);
    idle_gap();
    run_transform(-1);
    idle_gap();
    run_transform(PER + int'($urandom_range(PER - 1)));
    idle_gap();
    run_transform(-1);
    idle_gap();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
